// File: rtl/sevseg_scan_driver_if.sv
// Host-side handshake bundle for sevseg_scan_driver: the value to display,
// its load strobe, and the converter busy flag.
interface sevseg_scan_driver_if;
    logic [13:0] value;
    logic        load;
    logic        busy;

    // Controller core side: presents a value and strobes load
    modport master (
        output value,
        output load,
        input  busy
    );

    // Display driver side: accepts the value and reports busy
    modport slave (
        input  value,
        input  load,
        output busy
    );
endinterface

// File: rtl/sevseg_scan_driver.sv
// sevseg_scan_driver: 4-digit multiplexed seven-segment driver.
// A 14-bit value (saturated to 9999) is converted to BCD one double-dabble
// step per clock, then committed to the display registers. The scanner
// rotates through the four digits with a blanked lead-in per slot.
// Optional build macro SEVSEG_LZB_EN enables leading-zero blanking.
module sevseg_scan_driver #(
    parameter int REFRESH_DIV  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sevseg_scan_driver_if.slave   bus,
    output logic                  anode0_en,
    output logic                  anode1_en,
    output logic                  anode2_en,
    output logic                  anode3_en,
    output logic                  a_out,
    output logic                  b_out,
    output logic                  c_out,
    output logic                  d_out,
    output logic                  e_out,
    output logic                  f_out,
    output logic                  g_out
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]       state_reg;
    logic [3:0]       step_reg;
    logic [13:0]      bin_reg;
    logic [15:0]      bcd_reg;
    logic [15:0]      bcd_adj;
    logic [13:0]      value_sat;
    logic [3:0]       digit_reg [4];
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       idx_reg;
    logic [3:0]       anode_reg;
    logic [6:0]       seg_reg;
    logic [3:0]       anode_next;
    logic [6:0]       seg_next;
    logic [3:0]       digit_visible;
    logic             lit;

    // Out-of-range inputs display as the largest four-digit value
    assign value_sat = (bus.value > 14'd9999) ? 14'd9999 : bus.value;
    assign bus.busy  = (state_reg != ST_IDLE);

    // Double-dabble add-3 correction on every BCD nibble before the shift
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Conversion FSM: capture, 14 shift-add-3 steps, then commit to display
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            step_reg  <= 4'd0;
            bin_reg   <= 14'd0;
            bcd_reg   <= 16'd0;
            for (int i = 0; i < 4; i++) digit_reg[i] <= 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.load) begin
                        bin_reg   <= value_sat;
                        bcd_reg   <= 16'd0;
                        step_reg  <= 4'd0;
                        state_reg <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_reg  <= {bcd_adj[14:0], bin_reg[13]};
                    bin_reg  <= {bin_reg[12:0], 1'b0};
                    step_reg <= step_reg + 4'd1;
                    if (step_reg == 4'd13) state_reg <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < 4; i++) digit_reg[i] <= bcd_reg[i*4 +: 4];
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Slot timer and digit index; runs freely, independent of conversions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
            idx_reg <= 2'd0;
        end else if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Which digits may light: units always; higher ones depend on blanking mode
    assign digit_visible[0] = 1'b1;
`ifdef SEVSEG_LZB_EN
    logic [3:0] upper_nonzero;
    assign upper_nonzero[3] = (digit_reg[3] != 4'd0);
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_lzb
            assign upper_nonzero[gi] = (digit_reg[gi] != 4'd0) | upper_nonzero[gi+1];
        end
        for (genvar gi = 1; gi < 4; gi++) begin : g_vis
            assign digit_visible[gi] = upper_nonzero[gi];
        end
    endgenerate
    assign upper_nonzero[0] = 1'b1;
`else
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_vis
            assign digit_visible[gi] = 1'b1;
        end
    endgenerate
`endif

    // Segment pattern (gfedcba) of the current slot's digit
    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'b0111111;
            4'd1:    encode = 7'b0000110;
            4'd2:    encode = 7'b1011011;
            4'd3:    encode = 7'b1001111;
            4'd4:    encode = 7'b1100110;
            4'd5:    encode = 7'b1101101;
            4'd6:    encode = 7'b1111101;
            4'd7:    encode = 7'b0000111;
            4'd8:    encode = 7'b1111111;
            4'd9:    encode = 7'b1101111;
            default: encode = 7'b0000000;
        endcase
    endfunction

    // Drive selection: blank for the lead-in of each slot, otherwise one anode
    always_comb begin
        lit        = (cnt_reg >= CNT_W'(BLANK_CYCLES)) && digit_visible[idx_reg];
        anode_next = 4'd0;
        seg_next   = 7'd0;
        if (lit) begin
            anode_next = 4'b0001 << idx_reg;
            seg_next   = encode(digit_reg[idx_reg]);
        end
    end

    // Register pad drives so anodes and segments switch on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_reg <= 4'd0;
            seg_reg   <= 7'd0;
        end else begin
            anode_reg <= anode_next;
            seg_reg   <= seg_next;
        end
    end

    assign anode0_en = anode_reg[0];
    assign anode1_en = anode_reg[1];
    assign anode2_en = anode_reg[2];
    assign anode3_en = anode_reg[3];
    assign a_out     = seg_reg[0];
    assign b_out     = seg_reg[1];
    assign c_out     = seg_reg[2];
    assign d_out     = seg_reg[3];
    assign e_out     = seg_reg[4];
    assign f_out     = seg_reg[5];
    assign g_out     = seg_reg[6];
endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Testbench for sevseg_scan_driver: directed scenarios plus random loads,
// checked every cycle against a decimal-arithmetic reference model.
module tb_sevseg_scan_driver;
    localparam int RDIV  = 8;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic an0, an1, an2, an3;
    logic sa, sb, sc, sd, se, sf, sg;

    sevseg_scan_driver_if bus();

    sevseg_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .anode0_en(an0), .anode1_en(an1), .anode2_en(an2), .anode3_en(an3),
        .a_out(sa), .b_out(sb), .c_out(sc), .d_out(sd),
        .e_out(se), .f_out(sf), .g_out(sg)
    );

    always #5 clk = ~clk;

    logic [6:0] enc_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

    int checks = 0;
    int errors = 0;

    // reference model state
    int n;              // clock edges since reset release
    int m_num;          // number currently on display
    int m_pend;         // number being converted
    bit m_conv;
    int m_start;
    bit m_busy;

    logic [6:0] last_seg [4];
    bit         seen [4];

    logic [3:0] dut_an;
    logic [6:0] dut_seg;
    assign dut_an  = {an3, an2, an1, an0};
    assign dut_seg = {sg, sf, se, sd, sc, sb, sa};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, n);
        end
    endtask

    function automatic int digit_of(input int num, input int k);
        return (num / (10 ** k)) % 10;
    endfunction

    function automatic bit shown(input int num, input int k);
`ifdef SEVSEG_LZB_EN
        return (k == 0) || (num >= 10 ** k);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        n = 0; m_num = 0; m_pend = 0; m_conv = 0; m_start = 0; m_busy = 0;
    endtask

    task automatic clear_seen();
        for (int k = 0; k < 4; k++) begin
            seen[k] = 0;
            last_seg[k] = 7'd0;
        end
    endtask

    // One clock: advance the model across the edge and compare all outputs
    task automatic tick();
        bit ld;
        int v;
        int cnt, idx;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        ld = bus.load;
        v  = int'(bus.value);
        @(posedge clk);
        cnt = n % RDIV;
        idx = (n / RDIV) % 4;
        exp_an = 4'd0;
        exp_seg = 7'd0;
        if (cnt >= BLANK && shown(m_num, idx)) begin
            exp_an  = 4'(1 << idx);
            exp_seg = enc_tab[digit_of(m_num, idx)];
        end
        if (m_conv && n == m_start + 15) begin
            m_num  = m_pend;
            m_conv = 0;
        end
        if (ld && !m_busy) begin
            m_conv  = 1;
            m_start = n;
            m_pend  = (v > 9999) ? 9999 : v;
        end
        m_busy = m_conv && (n - m_start) <= 14;
        n++;
        #1;
        check("anodes", int'(dut_an), int'(exp_an));
        check("segments", int'(dut_seg), int'(exp_seg));
        check("busy", int'(bus.busy), int'(m_busy));
        check("onehot0", int'($countones(dut_an) <= 1), 1);
        check("blank_segs", int'(dut_an == 4'd0 && dut_seg != 7'd0), 0);
        for (int k = 0; k < 4; k++) begin
            if (dut_an[k]) begin
                seen[k] = 1;
                last_seg[k] = dut_seg;
            end
        end
    endtask

    task automatic do_load(input int val);
        bus.value = 14'(val);
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        $display("load value=%0d busy=%0b", val, bus.busy);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("rst_anodes", int'(dut_an), 0);
        check("rst_segments", int'(dut_seg), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int busy_cnt;
        bus.value = 14'd0;
        bus.load  = 1'b0;
        model_reset();
        clear_seen();
        #12;
        apply_reset();

        // 1: idle display of 0000 after reset
        run(2);
        check("lit_reset_blank", int'(dut_an), 0);
        tick();
        check("lit_anode0", int'(dut_an), 4'b0001);
        check("lit_seg0", int'(dut_seg), 7'b0111111);
        run(30);
        $display("test1 reset display done");

        // 2: 1234 with busy length
        bus.value = 14'd1234;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        busy_cnt = int'(bus.busy);
        for (int i = 0; i < 20; i++) begin
            tick();
            busy_cnt += int'(bus.busy);
        end
        check("lit_busy_len", busy_cnt, 15);
        clear_seen();
        run(40);
        check("lit_1234_d0", int'(last_seg[0]), 7'b1100110);
        check("lit_1234_d1", int'(last_seg[1]), 7'b1001111);
        check("lit_1234_d2", int'(last_seg[2]), 7'b1011011);
        check("lit_1234_d3", int'(last_seg[3]), 7'b0000110);

        // 3: saturation and exact 9999
        do_load(12000);
        run(20);
        clear_seen();
        run(40);
        for (int k = 0; k < 4; k++) check("lit_sat", int'(last_seg[k]), 7'b1101111);
        do_load(9999);
        run(20);
        clear_seen();
        run(40);
        for (int k = 0; k < 4; k++) check("lit_9999", int'(last_seg[k]), 7'b1101111);

        // 4: load during busy is dropped
        do_load(1234);
        run(4);
        do_load(5678);
        run(20);
        clear_seen();
        run(40);
        check("lit_drop_d0", int'(last_seg[0]), 7'b1100110);
        check("lit_drop_d3", int'(last_seg[3]), 7'b0000110);

        // 5: leading zeros
        do_load(7);
        run(20);
        clear_seen();
        run(40);
        check("lit_7_d0", int'(last_seg[0]), 7'b0000111);
`ifdef SEVSEG_LZB_EN
        for (int k = 1; k < 4; k++) check("lit_lzb_off", int'(seen[k]), 0);
`else
        for (int k = 1; k < 4; k++) check("lit_zero_shown", int'(last_seg[k]), 7'b0111111);
`endif

        // 6: reset in the middle of a conversion
        do_load(4321);
        run(6);
        apply_reset();
        run(3);
        clear_seen();
        run(40);
        check("lit_after_rst_d0", int'(last_seg[0]), 7'b0111111);
`ifndef SEVSEG_LZB_EN
        check("lit_after_rst_d3", int'(last_seg[3]), 7'b0111111);
`endif

        // 7: random loads, some during busy, some out of range
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) do_load(int'($urandom_range(0, 16383)));
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
